// File: rtl/rr_byte_mux_arbiter.sv
// Four-source round-robin arbiter sharing one 8-bit 4-to-1 byte mux, with a
// one-deep valid/ready output register and a completed-transfer counter.

module rr_byte_mux_8x4 (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic       sel1,
  input  logic       sel2,
  output logic [7:0] out
);

  always_comb begin
    case ({sel1, sel2})
      2'b00:   out = in1;
      2'b01:   out = in2;
      2'b10:   out = in3;
      default: out = in4;
    endcase
  end

endmodule

module rr_byte_mux_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [7:0]       in1,
  input  logic [7:0]       in2,
  input  logic [7:0]       in3,
  input  logic [7:0]       in4,
  output logic [3:0]       gnt,
  output logic             sel1,
  output logic             sel2,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [1:0]       ptr, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_d;
  logic             busy_d;
  logic [7:0]       out_data_d;
  logic             out_valid_d;
  logic [CNT_W-1:0] count_d;

  logic [7:0]       mux_out;
  logic [1:0]       pick;
  logic             found;
  logic             slot_free;

  rr_byte_mux_8x4 u_mux (
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .in4  (in4),
    .sel1 (sel_q[1]),
    .sel2 (sel_q[0]),
    .out  (mux_out)
  );

  // Rotating priority: scan ptr+1, ptr+2, ptr+3, then ptr itself.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[ptr + k[1:0]]) begin
        found = 1'b1;
        pick  = ptr + k[1:0];
      end
    end
  end

  // The output slot can take a new byte if empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    sel_d       = sel_q;
    ptr_d       = ptr;
    gnt_d       = 4'b0000;
    busy_d      = 1'b0;
    out_data_d  = out_data;
    out_valid_d = out_valid && !out_ready;
    count_d     = xfer_count;

    case (state)
      IDLE: begin
        if (found && slot_free) begin
          state_d = XFER;
          sel_d   = pick;
          gnt_d   = 4'b0001 << pick;
          busy_d  = 1'b1;
        end
      end
      XFER: begin
        // Capture happens regardless of whether the winner still requests.
        out_data_d  = mux_out;
        out_valid_d = 1'b1;
        ptr_d       = sel_q;
        count_d     = xfer_count + CNT_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 2'd3;
      sel_q      <= 2'd0;
      gnt        <= 4'b0000;
      busy       <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      xfer_count <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      sel_q      <= sel_d;
      gnt        <= gnt_d;
      busy       <= busy_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      xfer_count <= count_d;
    end
  end

  assign sel1 = sel_q[1];
  assign sel2 = sel_q[0];

endmodule

// File: tb/tb_rr_byte_mux_arbiter.sv
// Bench for rr_byte_mux_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.

module tb_rr_byte_mux_arbiter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [7:0]       in1, in2, in3, in4;
  logic [3:0]       gnt;
  logic             sel1, sel2;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] xfer_count;

  int checks = 0;
  int errors = 0;

  rr_byte_mux_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .in4        (in4),
    .gnt        (gnt),
    .sel1       (sel1),
    .sel2       (sel2),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  typedef logic [3:0][7:0] dset_t;  // [0]=in1 .. [3]=in4

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    dset_t       d;
    logic        rdy;
    logic [3:0]  e_gnt;
    logic [1:0]  e_sel;
    logic [7:0]  e_data;
    logic        e_valid;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] rq, input dset_t d, input logic rdy,
                     input logic [3:0] g, input logic [1:0] s, input logic [7:0] od,
                     input logic v, input logic b, input logic [15:0] c);
    vec_t x;
    x.rst = rst; x.rq = rq; x.d = d; x.rdy = rdy;
    x.e_gnt = g; x.e_sel = s; x.e_data = od; x.e_valid = v; x.e_busy = b; x.e_cnt = c;
    vecs.push_back(x);
  endtask

  // Drive inputs now, let one rising edge pass, return at the falling edge.
  task automatic apply(input logic rst, input logic [3:0] rq, input dset_t d, input logic rdy);
    reset = rst; req = rq; out_ready = rdy;
    in1 = d[0]; in2 = d[1]; in3 = d[2]; in4 = d[3];
    @(negedge clk);
  endtask

  task automatic compare(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic [7:0] od, input logic v, input logic b, input logic [15:0] c);
    check({tag, ".gnt"},   32'(gnt),          32'(g));
    check({tag, ".sel"},   32'({sel1, sel2}), 32'(s));
    check({tag, ".data"},  32'(out_data),     32'(od));
    check({tag, ".valid"}, 32'(out_valid),    32'(v));
    check({tag, ".busy"},  32'(busy),         32'(b));
    check({tag, ".count"}, 32'(xfer_count),   32'(c));
  endtask

  // Transaction-level reference: who is being served, who was served last,
  // and a queue standing in for the one-byte output slot.
  int   m_pend;
  int   m_last;
  int   m_cnt;
  int   m_sel;
  byte  m_data;
  byte  m_slot[$];

  task automatic model_step(input logic rst, input logic [3:0] rq, input dset_t d, input logic rdy);
    bit free;
    if (rst) begin
      m_pend = -1; m_last = 3; m_cnt = 0; m_sel = 0; m_data = 0;
      m_slot.delete();
    end else if (m_pend >= 0) begin
      if (m_slot.size() > 0 && rdy) void'(m_slot.pop_front());
      m_data = d[m_pend];
      m_slot.push_back(m_data);
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      m_last = m_pend;
      m_pend = -1;
    end else begin
      free = (m_slot.size() == 0) || rdy;
      if (m_slot.size() > 0 && rdy) void'(m_slot.pop_front());
      if (rq != 0 && free) begin
        for (int i = 1; i <= 4; i++) begin
          if (m_pend < 0 && rq[(m_last + i) % 4]) begin
            m_pend = (m_last + i) % 4;
            m_sel  = m_pend;
          end
        end
      end
    end
  endtask

  initial begin
    dset_t dd, da5, ds, d7e;
    dd  = {8'h44, 8'h33, 8'h22, 8'h11};
    da5 = {8'h44, 8'h33, 8'h22, 8'hA5};
    ds  = {8'h44, 8'h5C, 8'h22, 8'h11};
    d7e = {8'h44, 8'h33, 8'h7E, 8'h11};

    // First grant after reset, then a reset to restore the pointer.
    add(1, 4'h0, dd,  1, 4'h0, 2'd0, 8'h00, 0, 0, 0);
    add(0, 4'h1, da5, 1, 4'h1, 2'd0, 8'h00, 0, 1, 0);
    add(0, 4'h0, da5, 1, 4'h0, 2'd0, 8'hA5, 1, 0, 1);
    add(0, 4'h0, dd,  1, 4'h0, 2'd0, 8'hA5, 0, 0, 1);
    add(1, 4'h0, dd,  1, 4'h0, 2'd0, 8'h00, 0, 0, 0);
    // All four requesting: grants rotate 0,1,2,3,0.
    add(0, 4'hF, dd,  1, 4'h1, 2'd0, 8'h00, 0, 1, 0);
    add(0, 4'hF, dd,  1, 4'h0, 2'd0, 8'h11, 1, 0, 1);
    add(0, 4'hF, dd,  1, 4'h2, 2'd1, 8'h11, 0, 1, 1);
    add(0, 4'hF, dd,  1, 4'h0, 2'd1, 8'h22, 1, 0, 2);
    add(0, 4'hF, dd,  1, 4'h4, 2'd2, 8'h22, 0, 1, 2);
    add(0, 4'hF, dd,  1, 4'h0, 2'd2, 8'h33, 1, 0, 3);
    add(0, 4'hF, dd,  1, 4'h8, 2'd3, 8'h33, 0, 1, 3);
    add(0, 4'hF, dd,  1, 4'h0, 2'd3, 8'h44, 1, 0, 4);
    add(0, 4'hF, dd,  1, 4'h1, 2'd0, 8'h44, 0, 1, 4);
    add(0, 4'hF, dd,  1, 4'h0, 2'd0, 8'h11, 1, 0, 5);
    // Sources 1 and 3 only: alternate 1,3,1.
    add(0, 4'hA, dd,  1, 4'h2, 2'd1, 8'h11, 0, 1, 5);
    add(0, 4'hA, dd,  1, 4'h0, 2'd1, 8'h22, 1, 0, 6);
    add(0, 4'hA, dd,  1, 4'h8, 2'd3, 8'h22, 0, 1, 6);
    add(0, 4'hA, dd,  1, 4'h0, 2'd3, 8'h44, 1, 0, 7);
    add(0, 4'hA, dd,  1, 4'h2, 2'd1, 8'h44, 0, 1, 7);
    add(0, 4'hA, dd,  1, 4'h0, 2'd1, 8'h22, 1, 0, 8);
    // Consumer stall blocks arbitration until out_ready rises.
    add(0, 4'h0, dd,  0, 4'h0, 2'd1, 8'h22, 1, 0, 8);
    add(0, 4'h4, ds,  0, 4'h0, 2'd1, 8'h22, 1, 0, 8);
    add(0, 4'h4, ds,  0, 4'h0, 2'd1, 8'h22, 1, 0, 8);
    add(0, 4'h4, ds,  1, 4'h4, 2'd2, 8'h22, 0, 1, 8);
    add(0, 4'h0, ds,  0, 4'h0, 2'd2, 8'h5C, 1, 0, 9);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].rq, vecs[i].d, vecs[i].rdy);
      compare($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_sel, vecs[i].e_data,
              vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_cnt);
    end

    // Source 1 drops req while its byte is in XFER.
    apply(0, 4'h2, d7e, 1);
    compare("drop.gnt",  4'h2, 2'd1, 8'h5C, 0, 1, 9);
    apply(0, 4'h0, d7e, 1);
    compare("drop.cap",  4'h0, 2'd1, 8'h7E, 1, 0, 10);
    apply(0, 4'h0, d7e, 1);
    compare("drop.idle1", 4'h0, 2'd1, 8'h7E, 0, 0, 10);
    apply(0, 4'h0, d7e, 1);
    compare("drop.idle2", 4'h0, 2'd1, 8'h7E, 0, 0, 10);

    // Reset lands during XFER: byte discarded, pointer back to 3.
    apply(0, 4'hF, dd, 1);
    compare("rstx.gnt",  4'h4, 2'd2, 8'h7E, 0, 1, 10);
    apply(1, 4'hF, dd, 1);
    compare("rstx.rst",  4'h0, 2'd0, 8'h00, 0, 0, 0);
    apply(0, 4'hF, dd, 1);
    compare("rstx.gnt0", 4'h1, 2'd0, 8'h00, 0, 1, 0);
    apply(0, 4'hF, dd, 1);
    compare("rstx.cap",  4'h0, 2'd0, 8'h11, 1, 0, 1);

    // Randomized traffic against the model; cycle 0 forces a reset.
    for (int n = 0; n < 3000; n++) begin
      logic       rst, rdy;
      logic [3:0] rq;
      dset_t      d;
      logic [3:0] eg;
      rst = (n == 0) || ($urandom_range(0, 99) == 0);
      rq  = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
      model_step(rst, rq, d, rdy);
      apply(rst, rq, d, rdy);
      eg = (m_pend >= 0) ? (4'b0001 << m_pend) : 4'b0000;
      compare($sformatf("rand%0d", n), eg, 2'(m_sel), m_data,
              m_slot.size() > 0, m_pend >= 0, 16'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
